// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key-expansion controller: one round key per clock into an
// 11-entry register file, with a registered read port for the cipher engine.

module gen_key (
   input  logic [3:0]   round,
   input  logic [127:0] key_in,
   output logic [127:0] key_out
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };
   localparam logic [7:0] RCON [10] = '{
      8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36
   };

   logic [7:0]  rcon;
   logic [31:0] rot, temp, w0, w1, w2, w3;

   always_comb begin
      rcon = (round < 4'd10) ? RCON[round] : 8'h00;
      rot  = {key_in[23:0], key_in[31:24]};
      temp = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
             ^ {rcon, 24'h0};
      w0   = key_in[127:96] ^ temp;
      w1   = key_in[95:64]  ^ w0;
      w2   = key_in[63:32]  ^ w1;
      w3   = key_in[31:0]   ^ w2;
      key_out = {w0, w1, w2, w3};
   end
endmodule

module key_sched_ctrl #(
   parameter int NUM_RK = 11,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [127:0]     key_in,
   input  logic             key_valid,
   output logic             key_ready,
   output logic             busy,
   output logic             keys_valid,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [127:0]     rd_data,
   output logic             rd_valid
);
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(NUM_RK - 2);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] round_cnt;
   logic [127:0]     work_key, nk;
   logic [127:0]     rk [NUM_RK];
   logic             accept;

   gen_key u_gen_key (.round(round_cnt), .key_in(work_key), .key_out(nk));

   assign accept = key_valid && key_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXPAND;
         EXPAND:  if (round_cnt == LAST_RND) state_nxt = DONE;
         DONE:    if (accept) state_nxt = EXPAND;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      key_ready  = (state != EXPAND);
      busy       = (state == EXPAND);
      keys_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
         work_key  <= '0;
         round_cnt <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
      end else begin
         // Read samples the array before this edge's write lands.
         rd_valid <= rd_en;
         if (rd_en) rd_data <= (rd_idx < IDX_W'(NUM_RK)) ? rk[rd_idx] : '0;
         if (accept) begin
            rk[0]     <= key_in;
            work_key  <= key_in;
            round_cnt <= '0;
         end else if (state == EXPAND) begin
            rk[round_cnt + 1'b1] <= nk;
            work_key             <= nk;
            if (round_cnt != LAST_RND) round_cnt <= round_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: FIPS-197 vectors plus random keys checked against
// a word-level key-expansion model whose S-box is derived from GF(2^8) math.

module tb_key_sched_ctrl;
   logic         clk = 0;
   logic         rst, key_valid, rd_en;
   logic [127:0] key_in;
   logic [3:0]   rd_idx;
   logic         key_ready, busy, keys_valid, rd_valid;
   logic [127:0] rd_data;

   int n_tests = 0, n_fail = 0;
   logic [7:0]   sb [256];
   logic [127:0] exp_rk [11];

   key_sched_ctrl dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready), .busy(busy), .keys_valid(keys_valid),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, want);
      end
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 0, x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic rd(input int idx, output logic [127:0] d);
      rd_en = 1; rd_idx = 4'(idx);
      tick;
      chk("rd_valid", {127'b0, rd_valid}, 128'd1);
      d = rd_data;
      rd_en = 0;
   endtask

   // Called with the accept edge already taken; counts edges E0..E10.
   task automatic wait_done(input string tag);
      int lat = 1, bcnt = 0;
      while (!keys_valid && lat < 40) begin
         if (busy) bcnt++;
         tick; lat++;
      end
      chk({tag, "_busy_cycles"}, 128'(bcnt), 128'd10);
      chk({tag, "_latency"}, 128'(lat), 128'd11);
   endtask

   task automatic load(input logic [127:0] k, input string tag);
      key_in = k; key_valid = 1;
      chk({tag, "_ready"}, {127'b0, key_ready}, 128'd1);
      tick;
      key_valid = 0;
      chk({tag, "_kv_drop"}, {127'b0, keys_valid}, 128'd0);
      wait_done(tag);
   endtask

   task automatic check_all(input string tag);
      logic [127:0] d;
      for (int i = 0; i < 11; i++) begin
         rd(i, d);
         chk($sformatf("%s_rk%0d", tag, i), d, exp_rk[i]);
      end
   endtask

   initial begin
      logic [127:0] d, ka, kb, a10;
      build_sbox();
      rst = 1; key_valid = 0; key_in = '0; rd_en = 0; rd_idx = '0;
      tick; tick;
      rst = 0;
      chk("rst_ready", {127'b0, key_ready}, 128'd1);
      chk("rst_busy", {127'b0, busy}, 128'd0);
      chk("rst_kv", {127'b0, keys_valid}, 128'd0);
      chk("rst_rdv", {127'b0, rd_valid}, 128'd0);
      chk("rst_rdd", rd_data, 128'd0);

      // FIPS-197 appendix A.1
      load(128'h2b7e151628aed2a6abf7158809cf4f3c, "fips");
      rd(1, d);  chk("fips_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(10, d); chk("fips_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd(0, d);  chk("fips_rk0", d, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
      check_all("fips_model");

      // Second key held during expansion; taken only on the first DONE cycle.
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      model_expand(ka); a10 = exp_rk[10];
      key_in = ka; key_valid = 1;
      tick;
      key_in = kb;
      for (int i = 0; i < 40 && !keys_valid; i++) begin
         chk("hold_ready", {127'b0, key_ready}, 128'd0);
         tick;
      end
      chk("hold_done_kv", {127'b0, keys_valid}, 128'd1);
      chk("hold_done_ready", {127'b0, key_ready}, 128'd1);
      rd_en = 1; rd_idx = 4'd10;
      tick;
      rd_en = 0; key_valid = 0;
      chk("hold_old_rk10", rd_data, a10);
      chk("hold_b_busy", {127'b0, busy}, 128'd1);
      wait_done("hold_b");
      model_expand(kb);
      check_all("hold_b");

      // Reload from DONE.
      load(128'h000102030405060708090a0b0c0d0e0f, "reload");
      rd(10, d); chk("reload_rk10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // Reset in the middle of expansion.
      key_in = {$urandom, $urandom, $urandom, $urandom}; key_valid = 1;
      tick;
      key_valid = 0;
      repeat (5) tick;
      rst = 1; tick; rst = 0;
      chk("midrst_busy", {127'b0, busy}, 128'd0);
      chk("midrst_kv", {127'b0, keys_valid}, 128'd0);
      chk("midrst_ready", {127'b0, key_ready}, 128'd1);
      rd(3, d); chk("midrst_rk3", d, 128'd0);
      ka = {$urandom, $urandom, $urandom, $urandom};
      load(ka, "fresh");
      model_expand(ka);
      check_all("fresh");

      // Back-to-back reads across the full index range.
      rd_en = 1;
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         tick;
         chk($sformatf("b2b_v%0d", i), {127'b0, rd_valid}, 128'd1);
         chk($sformatf("b2b_d%0d", i), rd_data, (i < 11) ? exp_rk[i] : 128'd0);
      end
      rd_idx = 4'd5; tick;
      rd_en = 0; rd_idx = 4'd0; tick;
      chk("rd_idle_v", {127'b0, rd_valid}, 128'd0);
      chk("rd_idle_hold", rd_data, exp_rk[5]);

      // Reset and key_valid together: reset wins.
      rst = 1; key_valid = 1; key_in = {$urandom, $urandom, $urandom, $urandom};
      tick;
      rst = 0; key_valid = 0;
      chk("rstkv_kv", {127'b0, keys_valid}, 128'd0);
      chk("rstkv_busy", {127'b0, busy}, 128'd0);
      tick;
      chk("rstkv_busy2", {127'b0, busy}, 128'd0);
      rd(0, d); chk("rstkv_rk0", d, 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/key_sched_ctrl.md
Name: key_sched_ctrl

Overview:
- Iterative AES-128 key-expansion controller.
- Accepts one 128-bit cipher key over a valid/ready handshake.
- Sequences a single internal gen_key instance through rounds 0..9, one round per clock.
- Stores all 11 round keys (rk0..rk10) in an internal register file. The cipher round engine reads keys through a registered read port.

Parameters:
- NUM_RK, 11, number of stored round keys (rk0..rk10); fixed for AES-128.
- IDX_W, 4, width of round/read index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  cipher key; byte 0 in [127:120].
- key_valid  input  1  key_in valid; load occurs when key_valid && key_ready.
- key_ready  output  1  high when a new key is accepted (IDLE or DONE).
- busy  output  1  high while expansion is in progress.
- keys_valid  output  1  high when rk0..rk10 are all valid for the current key.
- rd_en  input  1  read request.
- rd_idx  input  4  round-key index to read (0..10).
- rd_data  output  128  registered read data.
- rd_valid  output  1  pulses one cycle after rd_en.

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, round_cnt=0.
  - All 11 key registers=0, rd_data=0, rd_valid=0, keys_valid=0, busy=0.
  - key_ready=1 from the first cycle after reset.
- States: IDLE, EXPAND, DONE.
- IDLE:
  - key_ready=1, busy=0, keys_valid=0.
  - On accept: rk[0]<=key_in, work_key<=key_in, round_cnt<=0, state<=EXPAND.
- EXPAND:
  - key_ready=0, busy=1.
  - Each edge: nk=gen_key(round=round_cnt, key_in=work_key); rk[round_cnt+1]<=nk; work_key<=nk; round_cnt<=round_cnt+1.
  - On the edge where round_cnt==9: state<=DONE, keys_valid<=1.
  - Exactly 10 EXPAND cycles. The gen_key round input always lies in 0..9, so rcon values 01,02,04,08,10,20,40,80,1b,36 are used in order.
- DONE:
  - keys_valid=1, key_ready=1, busy=0.
  - On a new accept: same actions as IDLE accept; keys_valid<=0 on that same edge. The old keys are overwritten progressively.
- Latency: key accepted at edge E0, then keys_valid=1 after edge E10, i.e. 11 cycles from accept to keys_valid.
- key_valid while busy: ignored, because key_ready=0. The key is not latched and the producer must hold it.
- Read port:
  - rd_en at edge N gives rd_data=rk[rd_idx] and rd_valid=1 after edge N; otherwise rd_valid<=0 and rd_data holds.
  - rd_idx>10 returns 128'h0.
  - Reads are legal in any state. Reading an index being written on the same edge returns the old value (read-before-write).
  - Consumers read only when keys_valid=1. Data read earlier is stale or zero but well-defined.
- Reset mid-EXPAND: aborts immediately. All outputs and storage return to reset values and key_ready=1 on the next cycle.
- Simultaneous rst and key_valid: rst wins; the key is not loaded.
- round_cnt never exceeds 9 in EXPAND and does not wrap. After DONE it holds until the next accept.

Test Plan:
- Reset then load FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - busy=1 for exactly 10 cycles and keys_valid rises 11 cycles after accept.
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_idx=0 -> the key itself.
- Hold key_valid=1 with a different key during EXPAND:
  - key_ready stays 0.
  - Stored keys are unchanged from the first key.
  - The second key is accepted only on the first DONE cycle.
- Reload in DONE with key 000102030405060708090a0b0c0d0e0f:
  - keys_valid drops on the accept edge and re-rises 11 cycles later.
  - rd_idx=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- Assert rst at EXPAND cycle 5:
  - Next cycle: busy=0, keys_valid=0, key_ready=1.
  - rd_idx=3 -> 0.
  - A fresh load then completes correctly.
- Read indices 0..15 back-to-back with rd_en held:
  - rd_valid high each cycle, with data 1 cycle behind the index.
  - Indices 11..15 -> 0.
- rst and key_valid high on the same edge: no load; state=IDLE and keys_valid=0 afterwards.
